fcp6_slave: RTL and testbench

FCP6_SLAVE -- requirements
Module: fcp6_slave

---
 rtl/fcp6_slave.sv | 206 ++++++++++++++++++++
 tb/tb_fcp6_slave.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcp6_slave.sv
// FCP6 bus slave: takes an 8-bit address/RW header over the dibit bus, then
// either accepts one write byte or returns one read byte with ack handshaking.
module fcp6_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h4C,
    parameter int         TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [1:0] data,
    inout  wire        ack,
    inout  wire  [1:0] ctrl,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       err
);

    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [1:0] CTRL_MST = 2'b01;
    localparam logic [1:0] CTRL_SLV = 2'b10;
    localparam logic [1:0] CTRL_END = 2'b11;

    typedef enum logic [2:0] {
        IDLE, HDR, HDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, END
    } state_t;

    state_t        state, next_state;
    logic [7:0]    hdr, shreg, tx_byte;
    logic [1:0]    cnt, retries;
    logic          byte_done, rd_turn;
    logic [TW-1:0] tcnt;

    logic          data_oe, ctrl_oe, ack_oe;
    logic [1:0]    data_q, ctrl_q;
    logic          data_oe_d, ctrl_oe_d, ack_oe_d, err_d;
    logic [1:0]    data_d, ctrl_d, rd_idx;

    logic          mst, fin, progress, timeout_hit, retry_abort, hdr_match;

    assign mst       = (ctrl == CTRL_MST);
    assign fin       = (ctrl == CTRL_END);
    assign hdr_match = (hdr[7:1] == SLAVE_ADDR);
    assign busy      = (state != IDLE);

    assign data = data_oe ? data_q : 2'bzz;
    assign ctrl = ctrl_oe ? ctrl_q : 2'bzz;
    assign ack  = ack_oe  ? 1'b0   : 1'bz;

    // Next state; progress marks cycles that restart the idle timeout.
    always_comb begin
        next_state  = state;
        progress    = 1'b0;
        retry_abort = 1'b0;
        case (state)
            IDLE:    if (mst) next_state = HDR;
            HDR: begin
                if (fin) begin
                    next_state = IDLE;
                end else if (mst) begin
                    progress = 1'b1;
                    if (cnt == 2'd0) next_state = HDR_ACK;
                end
            end
            HDR_ACK: begin
                if (!hdr_match)  next_state = IDLE;
                else if (hdr[0]) next_state = WR_DATA;
                else             next_state = RD_DATA;
            end
            WR_DATA: begin
                if (fin)                     next_state = byte_done ? WR_ACK : IDLE;
                else if (mst && !byte_done) progress = 1'b1;
            end
            WR_ACK:  next_state = END;
            RD_DATA: begin
                progress = 1'b1;
                if (!rd_turn && cnt == 2'd0) next_state = RD_ACK;
            end
            // A released ack reads 1 through the pull-up, so silence means accepted.
            RD_ACK: begin
                if (ack) begin
                    next_state = END;
                end else if (retries == 2'd3) begin
                    next_state  = IDLE;
                    retry_abort = 1'b1;
                end else begin
                    next_state = RD_DATA;
                end
            end
            END:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        timeout_hit = (state != IDLE) && (next_state == state) && !progress &&
                      (tcnt == TW'(TIMEOUT - 1));
        if (timeout_hit) next_state = IDLE;
        err_d = timeout_hit || retry_abort;
    end

    // Bus drive values for the coming cycle; registered below so lines switch cleanly.
    always_comb begin
        data_oe_d = 1'b0;
        data_d    = 2'b00;
        ctrl_oe_d = 1'b0;
        ctrl_d    = 2'b00;
        ack_oe_d  = 1'b0;
        rd_idx    = rd_turn ? cnt : cnt - 2'd1;
        case (next_state)
            HDR_ACK: ack_oe_d = ({hdr[7:2], data[1]} == SLAVE_ADDR);
            WR_ACK:  ack_oe_d = 1'b1;
            RD_DATA: begin
                if (state == RD_DATA) begin
                    data_oe_d = 1'b1;
                    data_d    = tx_byte[{rd_idx, 1'b0} +: 2];
                    ctrl_oe_d = 1'b1;
                    ctrl_d    = CTRL_SLV;
                end
            end
            END: begin
                ctrl_oe_d = 1'b1;
                ctrl_d    = CTRL_END;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hdr       <= 8'h00;
            shreg     <= 8'h00;
            tx_byte   <= 8'h00;
            cnt       <= 2'd0;
            retries   <= 2'd0;
            byte_done <= 1'b0;
            rd_turn   <= 1'b0;
            tcnt      <= '0;
            data_oe   <= 1'b0;
            data_q    <= 2'b00;
            ctrl_oe   <= 1'b0;
            ctrl_q    <= 2'b00;
            ack_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= next_state;
            data_oe  <= data_oe_d;
            data_q   <= data_d;
            ctrl_oe  <= ctrl_oe_d;
            ctrl_q   <= ctrl_d;
            ack_oe   <= ack_oe_d;
            rx_valid <= 1'b0;
            err      <= err_d;

            if (next_state != state || progress) tcnt <= '0;
            else if (state != IDLE)              tcnt <= tcnt + TW'(1);

            case (state)
                IDLE: begin
                    if (mst) begin
                        hdr <= {data, 6'b000000};
                        cnt <= 2'd2;
                    end
                end
                HDR: begin
                    if (!fin && mst) begin
                        hdr[{cnt, 1'b0} +: 2] <= data;
                        if (cnt != 2'd0) cnt <= cnt - 2'd1;
                    end
                end
                HDR_ACK: begin
                    cnt       <= 2'd3;
                    byte_done <= 1'b0;
                    rd_turn   <= 1'b1;
                    retries   <= 2'd0;
                    shreg     <= 8'h00;
                    if (hdr_match && !hdr[0]) tx_byte <= tx_data;
                end
                WR_DATA: begin
                    if (next_state == WR_ACK) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                    end else if (progress) begin
                        shreg <= {shreg[5:0], data};
                        if (cnt == 2'd0) byte_done <= 1'b1;
                        else             cnt       <= cnt - 2'd1;
                    end
                end
                // First RD_DATA cycle is a released turnaround; dibits follow.
                RD_DATA: begin
                    if (rd_turn)             rd_turn <= 1'b0;
                    else if (cnt != 2'd0)    cnt     <= cnt - 2'd1;
                end
                RD_ACK: begin
                    if (next_state == RD_DATA) begin
                        retries <= retries + 2'd1;
                        rd_turn <= 1'b1;
                        cnt     <= 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fcp6_slave.sv
// Directed self-checking bench for fcp6_slave; the tb plays the FCP6 master,
// driving at negedge and checking at negedge.
module tb_fcp6_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, busy, err;
    wire  [1:0] data;
    wire        ack;
    wire  [1:0] ctrl;

    logic [1:0] m_data, m_ctrl;
    logic       m_data_oe, m_ctrl_oe, m_ack, m_ack_oe;
    logic [1:0] rd_exp [4];

    int checks = 0;
    int errors = 0;

    assign data = m_data_oe ? m_data : 2'bzz;
    assign ctrl = m_ctrl_oe ? m_ctrl : 2'bzz;
    assign ack  = m_ack_oe  ? m_ack  : 1'bz;

    // Released data/ctrl read 00 and released ack reads 1, so drive can be observed.
    pulldown (data[0]);
    pulldown (data[1]);
    pulldown (ctrl[0]);
    pulldown (ctrl[1]);
    pullup   (ack);

    always #5 clk = ~clk;

    fcp6_slave #(.SLAVE_ADDR(7'h4C), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .data(data), .ack(ack), .ctrl(ctrl),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_master(input logic [1:0] c, input logic [1:0] d);
        m_ctrl_oe = 1'b1;
        m_ctrl    = c;
        m_data_oe = 1'b1;
        m_data    = d;
    endtask

    task automatic release_bus();
        m_ctrl_oe = 1'b0;
        m_data_oe = 1'b0;
        m_ack_oe  = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] h);
        for (int i = 3; i >= 0; i--) begin
            drive_master(2'b01, h[2*i +: 2]);
            tick();
        end
        release_bus();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, rx_valid, err, rx_data} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", {busy, rx_valid, err, rx_data}, 11'h000);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({ack, ctrl, data} !== 5'b1_00_00) begin
            errors++;
            $display("[TB] FAIL reset_lines: got %b expected %b", {ack, ctrl, data}, 5'b1_00_00);
        end
    endtask

    task automatic test_write();
        logic [7:0] wbyte;
        wbyte = 8'h99;
        send_header(8'h99);
        checks++;
        if ({ack, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL write_hdr_ack: got %b expected %b", {ack, busy}, 2'b01);
        end
        tick();
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_ack_release: got %b expected %b", ack, 1'b1);
        end
        for (int i = 3; i >= 0; i--) begin
            drive_master(2'b01, wbyte[2*i +: 2]);
            tick();
        end
        drive_master(2'b11, 2'b00);
        tick();
        release_bus();
        #1;
        checks++;
        if ({ack, rx_valid, rx_data} !== {1'b0, 1'b1, 8'h99}) begin
            errors++;
            $display("[TB] FAIL write_wr_ack: got %h expected %h", {ack, rx_valid, rx_data}, {1'b0, 1'b1, 8'h99});
        end
        tick();
        checks++;
        if ({ctrl, rx_valid, busy, ack} !== 5'b11_0_1_1) begin
            errors++;
            $display("[TB] FAIL write_end: got %b expected %b", {ctrl, rx_valid, busy, ack}, 5'b11_0_1_1);
        end
        tick();
        checks++;
        if ({busy, ctrl, rx_data} !== {3'b000, 8'h99}) begin
            errors++;
            $display("[TB] FAIL write_idle: got %h expected %h", {busy, ctrl, rx_data}, {3'b000, 8'h99});
        end
    endtask

    task automatic test_mismatch();
        send_header(8'h31);
        checks++;
        if ({ack, ctrl, data, busy} !== 6'b1_00_00_1) begin
            errors++;
            $display("[TB] FAIL mismatch_nack: got %b expected %b", {ack, ctrl, data, busy}, 6'b1_00_00_1);
        end
        tick();
        checks++;
        if ({busy, rx_valid, ctrl, rx_data} !== {4'b0000, 8'h99}) begin
            errors++;
            $display("[TB] FAIL mismatch_idle: got %h expected %h", {busy, rx_valid, ctrl, rx_data}, {4'b0000, 8'h99});
        end
    endtask

    task automatic test_read();
        tx_data = 8'hA5;
        send_header(8'h98);
        checks++;
        if ({ack, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL read_hdr_ack: got %b expected %b", {ack, busy}, 2'b01);
        end
        tick();
        tx_data = 8'h3C;
        checks++;
        if ({ack, ctrl, data} !== 5'b1_00_00) begin
            errors++;
            $display("[TB] FAIL read_turnaround: got %b expected %b", {ack, ctrl, data}, 5'b1_00_00);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ctrl, data} !== {2'b10, rd_exp[i]}) begin
                errors++;
                $display("[TB] FAIL read_dibit%0d: got %b expected %b", i, {ctrl, data}, {2'b10, rd_exp[i]});
            end
        end
        tick();
        checks++;
        if ({ctrl, data} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL read_release: got %b expected %b", {ctrl, data}, 4'b0000);
        end
        m_ack_oe = 1'b1;
        m_ack    = 1'b1;
        tick();
        release_bus();
        #1;
        checks++;
        if ({ctrl, busy} !== 3'b11_1) begin
            errors++;
            $display("[TB] FAIL read_end: got %b expected %b", {ctrl, busy}, 3'b11_1);
        end
        tick();
        checks++;
        if ({busy, ctrl, err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL read_idle: got %b expected %b", {busy, ctrl, err}, 4'b0000);
        end
    endtask

    task automatic test_read_retry(input int sends);
        tx_data = 8'hA5;
        send_header(8'h98);
        for (int s = 0; s < sends; s++) begin
            tick();
            release_bus();
            #1;
            checks++;
            if ({ctrl, data, busy} !== 5'b00_00_1) begin
                errors++;
                $display("[TB] FAIL retry_turn%0d: got %b expected %b", s, {ctrl, data, busy}, 5'b00_00_1);
            end
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if ({ctrl, data} !== {2'b10, rd_exp[i]}) begin
                    errors++;
                    $display("[TB] FAIL retry_send%0d_dibit%0d: got %b expected %b", s, i, {ctrl, data}, {2'b10, rd_exp[i]});
                end
            end
            tick();
            m_ack_oe = 1'b1;
            m_ack    = (sends == 3 && s == 2);
        end
        tick();
        release_bus();
        #1;
        if (sends == 3) begin
            checks++;
            if ({ctrl, busy, err} !== 4'b11_1_0) begin
                errors++;
                $display("[TB] FAIL retry_end: got %b expected %b", {ctrl, busy, err}, 4'b11_1_0);
            end
            tick();
            checks++;
            if ({busy, err} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL retry_idle: got %b expected %b", {busy, err}, 2'b00);
            end
        end else begin
            checks++;
            if ({err, busy, ctrl, data} !== 6'b1_0_00_00) begin
                errors++;
                $display("[TB] FAIL retry_abort: got %b expected %b", {err, busy, ctrl, data}, 6'b1_0_00_00);
            end
            tick();
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL retry_err_pulse: got %b expected %b", err, 1'b0);
            end
        end
    endtask

    task automatic test_timeout();
        send_header(8'h99);
        tick();
        repeat (15) tick();
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL timeout_early: got %b expected %b", {busy, err}, 2'b10);
        end
        tick();
        checks++;
        if ({err, busy, ack, ctrl, data} !== 7'b1_0_1_00_00) begin
            errors++;
            $display("[TB] FAIL timeout_abort: got %b expected %b", {err, busy, ack, ctrl, data}, 7'b1_0_1_00_00);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_err_pulse: got %b expected %b", err, 1'b0);
        end
    endtask

    task automatic test_abort();
        drive_master(2'b01, 2'b10);
        tick();
        drive_master(2'b11, 2'b00);
        tick();
        release_bus();
        #1;
        checks++;
        if ({busy, err} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL abort_hdr: got %b expected %b", {busy, err}, 2'b00);
        end
        send_header(8'h99);
        tick();
        drive_master(2'b01, 2'b10);
        tick();
        drive_master(2'b01, 2'b01);
        tick();
        drive_master(2'b11, 2'b00);
        tick();
        release_bus();
        #1;
        checks++;
        if ({busy, err, rx_valid, ack} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL abort_write: got %b expected %b", {busy, err, rx_valid, ack}, 4'b0001);
        end
        tick();
        checks++;
        if ({rx_valid, rx_data} !== {1'b0, 8'h99}) begin
            errors++;
            $display("[TB] FAIL abort_rx_keep: got %h expected %h", {rx_valid, rx_data}, {1'b0, 8'h99});
        end
    endtask

    task automatic test_reset_mid_write();
        send_header(8'h99);
        tick();
        drive_master(2'b01, 2'b10);
        tick();
        drive_master(2'b01, 2'b01);
        tick();
        release_bus();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, rx_valid, ack, ctrl, data, rx_data} !== {7'b0_0_1_00_00, 8'h00}) begin
            errors++;
            $display("[TB] FAIL rst_write: got %h expected %h", {busy, rx_valid, ack, ctrl, data, rx_data}, {7'b0_0_1_00_00, 8'h00});
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rx_valid, busy} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL rst_write_quiet%0d: got %b expected %b", i, {rx_valid, busy}, 2'b00);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        tx_data = 8'hA5;
        send_header(8'h98);
        tick();
        tick();
        checks++;
        if ({ctrl, data} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL rst_read_drive: got %b expected %b", {ctrl, data}, 4'b1010);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({ctrl, data, busy, ack} !== 6'b00_00_0_1) begin
            errors++;
            $display("[TB] FAIL rst_read_release: got %b expected %b", {ctrl, data, busy, ack}, 6'b00_00_0_1);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rd_exp    = '{2'b10, 2'b10, 2'b01, 2'b01};
        m_data    = 2'b00;
        m_ctrl    = 2'b00;
        m_ack     = 1'b1;
        m_data_oe = 1'b0;
        m_ctrl_oe = 1'b0;
        m_ack_oe  = 1'b0;
        tx_data   = 8'h00;
        rst       = 1'b1;

        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_read_retry(3);
        test_read_retry(4);
        test_timeout();
        test_abort();
        test_reset_mid_write();
        test_reset_mid_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
